flash_bist: RTL and testbench
=============================

// Module: flash_bist
// PURPOSE
//   Parametrised flash self-test sequencer driving flash_ctl (read/write/addr/din/dout/busy).
//   Sweeps NUM_WORDS addresses from BASE_ADDR: write pattern, verify readback, or write-then-verify.
//   Started by board buttons; reports status on LEDs and through err_count/fail_addr. Board top-level test block.
// PARAMETERS
//   ADDR_W        16       flash address width
//   DATA_W        8        flash data width
//   BASE_ADDR     16'h01AA first address of sweep (ADDR_W bits)
//   NUM_WORDS     16       words per sweep, >=1; address wraps modulo 2^ADDR_W
//   PATTERN_SEED  8'h55    pattern = addr[DATA_W-1:0] ^ SEED (SEED zero-extended/truncated to DATA_W)
//   HOLD_CYCLES   255      cycles the DONE LED state is held before IDLE
//   TIMEOUT_CYCLES 1024    busy watchdog limit (FLASH_BIST_TIMEOUT_EN only)
// PORTS
//   clk       in  1       system clock
//   reset     in  1       synchronous, active-low reset
//   BTN1      in  1       async button: write sweep
//   BTN2      in  1       async button: verify sweep
//   read      out 1       one-cycle read strobe to flash_ctl
//   write     out 1       one-cycle write strobe to flash_ctl
//   addr      out ADDR_W  flash address, stable from strobe until op complete
//   din       out DATA_W  write data (pattern), stable with addr
//   dout      in  DATA_W  read data from flash_ctl, valid when busy low after read
//   busy      in  1       flash_ctl operation in progress
//   LED1      out 1       idle
//   LED2      out 1       sweep running / fail indicator
//   LED3      out 1       sweep done
//   err_count out 8       mismatches in last verify, saturates at 8'hFF
//   fail_addr out ADDR_W  address of first mismatch of last verify (0 if none)
// BEHAVIOUR
//   Reset (reset==0 at posedge clk): state IDLE, read=write=0, addr=BASE_ADDR, din=0,
//     LED1=1, LED2=LED3=0, err_count=0, fail_addr=0, sync/edge flops cleared. Reset mid-sweep aborts at once.
//   Buttons: 2-flop synchroniser each, rising-edge detect; held button starts exactly one sweep.
//     Start only in IDLE with busy==0. BTN1 edge -> WRITE; BTN2 edge -> VERIFY; both edges same cycle,
//     or edge on one while other synced high -> FULL (write pass then verify pass). Edges outside IDLE ignored.
//   Sweep start: word index=0, addr=BASE_ADDR; VERIFY/FULL clear err_count and fail_addr.
//   States: IDLE -> ISSUE -> WSTART -> WDONE -> (CHECK) -> NEXT -> ... -> DONE -> IDLE
//     ISSUE : drive addr, din=pattern(addr); pulse write (write pass) or read (verify pass) 1 cycle.
//     WSTART: wait busy==1 (strobe accepted); WDONE: wait busy==0.
//     CHECK : verify only; sample dout the cycle after busy seen low; mismatch vs pattern ->
//             err_count+1 (sat), fail_addr=addr if first mismatch this sweep.
//     NEXT  : last word -> FULL write pass: index=0, addr=BASE_ADDR, switch to verify, ISSUE;
//             otherwise DONE. Else index+1, addr+1 (wrap modulo 2^ADDR_W), ISSUE.
//     DONE  : hold HOLD_CYCLES cycles (counter HOLD_CYCLES..0), then IDLE.
//   Strobes never overlap; at most one operation outstanding; read and write never both 1.
//   LEDs: IDLE LED1 only; running LED2 only; DONE pass LED3 only; DONE fail (err_count!=0) LED2+LED3.
//   err_count/fail_addr retained until next VERIFY/FULL start; WRITE-only sweep leaves them unchanged.
// CONFIGURATION
//   FLASH_BIST_TIMEOUT_EN defined: cycle counter runs in WSTART/WDONE, cleared on ISSUE; reaching
//     TIMEOUT_CYCLES aborts sweep -> err_count=8'hFF, fail_addr=current addr, DONE (fail LEDs).
//   Undefined: no watchdog logic; WSTART/WDONE wait indefinitely.
// STRUCTURE
//   Package flash_bist_pkg: state encoding constants, mode encoding (WRITE/VERIFY/FULL), pattern function.
//   Sub-module btn_sync_edge (2-flop sync + rising-edge pulse), instantiated per button.
// TESTING (bench has behavioural flash_ctl model, busy high 3-10 cycles per op)
//   NUM_WORDS=4, BTN1 pulse -> 4 write strobes, addr 01AA..01AD, din FF,FE,F9,F8; DONE LED3 only.
//   Both buttons same cycle, clean model -> 4 writes then 4 reads; err_count=0, fail_addr=0, LED3 only.
//   BTN2, model returns 8'h00 at 01AB and 01AD -> err_count=2, fail_addr=01AB, LED2+LED3 in DONE.
//   BASE_ADDR=16'hFFFE, NUM_WORDS=4, BTN1 -> addrs FFFE,FFFF,0000,0001 (wrap).
//   reset=0 during 2nd WDONE -> next edge read=write=0, LED1=1, no further strobes; BTN1 held 1000 cycles -> one sweep.
//   FLASH_BIST_TIMEOUT_EN, busy stuck 1 -> abort after 1024 cycles, err_count=FF; undefined -> stays WDONE.

Source files
------------

// File: rtl/flash_bist_pkg.sv
// rtl/flash_bist_pkg.sv - shared types and pattern helper for the flash self-test sequencer
package flash_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WSTART,
      S_WDONE,
      S_CHECK,
      S_NEXT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      MODE_WRITE,
      MODE_VERIFY,
      MODE_FULL
   } mode_t;

   // Test pattern for a word: low address bits XOR the seed; callers truncate to DATA_W.
   function automatic logic [31:0] pattern_word(input logic [31:0] addr, input logic [31:0] seed);
      return addr ^ seed;
   endfunction

endpackage

// File: rtl/flash_bist_if.sv
// rtl/flash_bist_if.sv - flash_ctl command/data bundle between the sequencer and the controller
interface flash_bist_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) ();
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              busy;

   modport master (output read, output write, output addr, output din, input dout, input busy);
   modport slave  (input read, input write, input addr, input din, output dout, output busy);
endinterface

// File: rtl/flash_bist_btn_sync_edge.sv
// rtl/flash_bist_btn_sync_edge.sv - two-flop button synchroniser with rising-edge pulse
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic rise
);
   logic meta, sync, prev;

   // Synchronise the asynchronous button and keep last synced value for edge detection.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;
endmodule

// File: rtl/flash_bist.sv
// rtl/flash_bist.sv - flash self-test sequencer; FLASH_BIST_TIMEOUT_EN adds a busy watchdog
module flash_bist
   import flash_bist_pkg::*;
#(
   parameter int                ADDR_W         = 16,
   parameter int                DATA_W         = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR      = 16'h01AA,
   parameter int                NUM_WORDS      = 16,
   parameter int unsigned       PATTERN_SEED   = 32'h55,
   parameter int                HOLD_CYCLES    = 255,
   parameter int                TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              BTN1,
   input  logic              BTN2,
   flash_bist_if.master      flash,
   output logic              LED1,
   output logic              LED2,
   output logic              LED3,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] fail_addr
);
   localparam int IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int CMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1) + 1;

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
      return DATA_W'(pattern_word(32'(a), PATTERN_SEED));
   endfunction

   state_t            state_q, state_nxt;
   mode_t             mode_q, mode_nxt;
   logic              verify_q, verify_nxt;
   logic [IW-1:0]     idx_q, idx_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] din_q, din_nxt;
   logic [7:0]        err_q, err_nxt;
   logic [ADDR_W-1:0] fail_q, fail_nxt;
   logic [CW-1:0]     cnt_q, cnt_nxt;
   logic              lvl1, rise1, lvl2, rise2;

   btn_sync_edge u_btn1 (.clk(clk), .reset(reset), .btn(BTN1), .level(lvl1), .rise(rise1));
   btn_sync_edge u_btn2 (.clk(clk), .reset(reset), .btn(BTN2), .level(lvl2), .rise(rise2));

   // State and datapath registers; reset aborts any sweep immediately.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         mode_q   <= MODE_WRITE;
         verify_q <= 1'b0;
         idx_q    <= '0;
         addr_q   <= BASE_ADDR;
         din_q    <= '0;
         err_q    <= 8'd0;
         fail_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_nxt;
         mode_q   <= mode_nxt;
         verify_q <= verify_nxt;
         idx_q    <= idx_nxt;
         addr_q   <= addr_nxt;
         din_q    <= din_nxt;
         err_q    <= err_nxt;
         fail_q   <= fail_nxt;
         cnt_q    <= cnt_nxt;
      end
   end

   // Sweep sequencing: start decode, one operation at a time, verify compare, hold in DONE.
   always_comb begin
      state_nxt  = state_q;
      mode_nxt   = mode_q;
      verify_nxt = verify_q;
      idx_nxt    = idx_q;
      addr_nxt   = addr_q;
      din_nxt    = din_q;
      err_nxt    = err_q;
      fail_nxt   = fail_q;
      cnt_nxt    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!flash.busy && (rise1 || rise2)) begin
               if ((rise1 && lvl2) || (rise2 && lvl1)) mode_nxt = MODE_FULL;
               else if (rise1)                          mode_nxt = MODE_WRITE;
               else                                     mode_nxt = MODE_VERIFY;
               verify_nxt = (mode_nxt == MODE_VERIFY);
               if (mode_nxt != MODE_WRITE) begin
                  err_nxt  = 8'd0;
                  fail_nxt = '0;
               end
               idx_nxt   = '0;
               addr_nxt  = BASE_ADDR;
               din_nxt   = pat(BASE_ADDR);
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = S_WSTART;
         end
         S_WSTART, S_WDONE: begin
            if (state_q == S_WSTART) begin
               if (flash.busy) state_nxt = S_WDONE;
            end else if (!flash.busy) begin
               state_nxt = verify_q ? S_CHECK : S_NEXT;
            end
`ifdef FLASH_BIST_TIMEOUT_EN
            cnt_nxt = cnt_q + CW'(1);
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               err_nxt   = 8'hFF;
               fail_nxt  = addr_q;
               cnt_nxt   = CW'(HOLD_CYCLES);
               state_nxt = S_DONE;
            end
`endif
         end
         S_CHECK: begin
            if (flash.dout != pat(addr_q)) begin
               if (err_q == 8'd0)  fail_nxt = addr_q;
               if (err_q != 8'hFF) err_nxt  = err_q + 8'd1;
            end
            state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (idx_q == IW'(NUM_WORDS - 1)) begin
               if (mode_q == MODE_FULL && !verify_q) begin
                  verify_nxt = 1'b1;
                  idx_nxt    = '0;
                  addr_nxt   = BASE_ADDR;
                  din_nxt    = pat(BASE_ADDR);
                  state_nxt  = S_ISSUE;
               end else begin
                  cnt_nxt   = CW'(HOLD_CYCLES);
                  state_nxt = S_DONE;
               end
            end else begin
               idx_nxt   = idx_q + IW'(1);
               addr_nxt  = addr_q + ADDR_W'(1);
               din_nxt   = pat(addr_q + ADDR_W'(1));
               state_nxt = S_ISSUE;
            end
         end
         S_DONE: begin
            if (cnt_q == '0) state_nxt = S_IDLE;
            else             cnt_nxt   = cnt_q - CW'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign flash.read  = (state_q == S_ISSUE) &&  verify_q;
   assign flash.write = (state_q == S_ISSUE) && !verify_q;
   assign flash.addr  = addr_q;
   assign flash.din   = din_q;

   assign LED1      = (state_q == S_IDLE);
   assign LED2      = (state_q == S_DONE) ? (err_q != 8'd0) : (state_q != S_IDLE);
   assign LED3      = (state_q == S_DONE);
   assign err_count = err_q;
   assign fail_addr = fail_q;
endmodule

// File: tb/tb_flash_bist.sv
// tb/tb_flash_bist.sv - randomized self-checking bench with behavioural flash_ctl model
module tb_flash_bist;
   typedef struct packed {
      logic        is_wr;
      logic [15:0] a;
      logic [7:0]  d;
   } op_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn = 1'b0;
   logic a_b1 = 1'b0, a_b2 = 1'b0, b_b1 = 1'b0, b_b2 = 1'b0;
   logic a_l1, a_l2, a_l3, b_l1, b_l2, b_l3;
   logic [7:0]  a_err, b_err;
   logic [15:0] a_fail, b_fail;

   flash_bist_if #(.ADDR_W(16), .DATA_W(8)) fa ();
   flash_bist_if #(.ADDR_W(16), .DATA_W(8)) fb ();

   flash_bist #(.NUM_WORDS(4)) dut_a (
      .clk(clk), .reset(rstn), .BTN1(a_b1), .BTN2(a_b2), .flash(fa),
      .LED1(a_l1), .LED2(a_l2), .LED3(a_l3), .err_count(a_err), .fail_addr(a_fail));

   flash_bist #(.BASE_ADDR(16'hFFFE), .NUM_WORDS(4), .HOLD_CYCLES(20)) dut_b (
      .clk(clk), .reset(rstn), .BTN1(b_b1), .BTN2(b_b2), .flash(fb),
      .LED1(b_l1), .LED2(b_l2), .LED3(b_l3), .err_count(b_err), .fail_addr(b_fail));

   // Behavioural flash_ctl: busy 3..10 cycles per op, memory, injected read faults on A.
   logic        rd [2], wr [2];
   logic [15:0] ad [2];
   logic [7:0]  dn [2];
   logic        bz [2]    = '{1'b0, 1'b0};
   logic        stuck [2] = '{1'b0, 1'b0};
   logic [7:0]  rdata [2] = '{8'h00, 8'h00};
   int          left [2]  = '{0, 0};
   int          viol      = 0;
   logic [7:0]  mem [131072];
   logic [7:0]  bad [int];
   op_t         log_a [$];
   op_t         log_b [$];

   assign rd[0] = fa.read;  assign wr[0] = fa.write; assign ad[0] = fa.addr; assign dn[0] = fa.din;
   assign rd[1] = fb.read;  assign wr[1] = fb.write; assign ad[1] = fb.addr; assign dn[1] = fb.din;
   assign fa.busy = bz[0];  assign fa.dout = rdata[0];
   assign fb.busy = bz[1];  assign fb.dout = rdata[1];

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rd[g] || wr[g]) begin
            if ((rd[g] && wr[g]) || bz[g]) viol <= viol + 1;
            if (g == 0) log_a.push_back({wr[g], ad[g], dn[g]});
            else        log_b.push_back({wr[g], ad[g], dn[g]});
            bz[g]   <= 1'b1;
            left[g] <= int'($urandom_range(9, 2));
            if (wr[g])                            mem[{g[0], ad[g]}] <= dn[g];
            else if (g == 0 && bad.exists(ad[g])) rdata[g] <= bad[ad[g]];
            else                                  rdata[g] <= mem[{g[0], ad[g]}];
         end else if (bz[g] && !stuck[g]) begin
            if (left[g] == 0) bz[g]   <= 1'b0;
            else              left[g] <= left[g] - 1;
         end
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_for(input int sel, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((sel == 0 && a_l3) || (sel == 1 && a_l1) || (sel == 2 && b_l3) || (sel == 3 && b_l1)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic press_a(input logic p1, input logic p2, input int cycles);
      @(negedge clk);
      a_b1 = p1;
      a_b2 = p2;
      repeat (cycles) @(negedge clk);
      a_b1 = 1'b0;
      a_b2 = 1'b0;
   endtask

   logic [7:0]  exp_err  = 8'd0;
   logic [15:0] exp_fail = 16'd0;

   // mode: 0 write sweep, 1 verify sweep, 2 write-then-verify
   task automatic run_a(input int mode, input string tag);
      op_t         exp_q [$];
      logic        passes [$];
      logic [15:0] a;
      bit          ok;
      if (mode == 0)      passes = '{1'b1};
      else if (mode == 1) passes = '{1'b0};
      else                passes = '{1'b1, 1'b0};
      foreach (passes[p]) begin
         for (int i = 0; i < 4; i++) begin
            a = 16'h01AA + 16'(i);
            exp_q.push_back({passes[p], a, a[7:0] ^ 8'h55});
         end
      end
      if (mode != 0) begin
         exp_err  = 8'd0;
         exp_fail = 16'd0;
         for (int i = 0; i < 4; i++) begin
            a = 16'h01AA + 16'(i);
            if (bad.exists(a)) begin
               if (exp_err == 8'd0) exp_fail = a;
               exp_err = exp_err + 8'd1;
            end
         end
      end
      log_a.delete();
      press_a(mode != 1, mode != 0, 4);
      chk({tag, " running leds"}, {a_l1, a_l2, a_l3}, 3'b010);
      wait_for(0, 3000, ok);
      chk({tag, " done reached"}, ok, 1);
      chk({tag, " done leds"}, {a_l1, a_l2, a_l3}, {1'b0, exp_err != 8'd0, 1'b1});
      chk({tag, " err_count"}, a_err, exp_err);
      chk({tag, " fail_addr"}, a_fail, exp_fail);
      chk({tag, " op count"}, log_a.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < log_a.size()) chk($sformatf("%s op%0d", tag, i), log_a[i], exp_q[i]);
      wait_for(1, 400, ok);
      chk({tag, " back to idle"}, ok, 1);
   endtask

   initial begin
      bit          ok;
      int          cnt;
      logic [15:0] a;
      logic [7:0]  p;

      repeat (3) @(negedge clk);
      chk("reset strobes", {fa.read, fa.write, fb.read, fb.write}, 4'b0000);
      chk("reset leds", {a_l1, a_l2, a_l3}, 3'b100);
      chk("reset err_count", a_err, 8'd0);
      chk("reset fail_addr", a_fail, 16'd0);
      chk("reset addr a", fa.addr, 16'h01AA);
      chk("reset addr b", fb.addr, 16'hFFFE);
      chk("reset din", fa.din, 8'h00);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      run_a(0, "write");
      run_a(2, "full");
      bad[32'h01AB] = 8'h00;
      bad[32'h01AD] = 8'h00;
      run_a(1, "verify_bad");

      for (int r = 0; r < 6; r++) begin
         bad.delete();
         for (int i = 0; i < 4; i++) begin
            a = 16'h01AA + 16'(i);
            p = a[7:0] ^ 8'h55;
            if ($urandom_range(2, 0) == 0) bad[a] = p ^ 8'($urandom_range(255, 1));
         end
         run_a(int'($urandom_range(2, 0)), $sformatf("rnd%0d", r));
      end
      bad.delete();

      log_b.delete();
      @(negedge clk);
      b_b1 = 1'b1;
      repeat (4) @(negedge clk);
      b_b1 = 1'b0;
      wait_for(2, 2000, ok);
      chk("wrap done", ok, 1);
      chk("wrap leds", {b_l1, b_l2, b_l3}, 3'b001);
      chk("wrap op count", log_b.size(), 4);
      for (int i = 0; i < 4; i++) begin
         a = 16'hFFFE + 16'(i);
         if (i < log_b.size()) chk($sformatf("wrap op%0d", i), log_b[i], {1'b1, a, a[7:0] ^ 8'h55});
      end
      wait_for(3, 200, ok);
      chk("wrap idle", ok, 1);

      log_a.delete();
      press_a(1'b1, 1'b0, 4);
      ok = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (log_a.size() >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst reached op2", ok, 1);
      @(negedge clk);
      chk("rst mid busy", fa.busy, 1'b1);
      rstn = 1'b0;
      @(negedge clk);
      chk("rst mid strobes", {fa.read, fa.write}, 2'b00);
      chk("rst mid leds", {a_l1, a_l2, a_l3}, 3'b100);
      chk("rst mid err_count", a_err, 8'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (300) @(negedge clk);
      chk("rst no further ops", log_a.size(), 2);
      exp_err  = 8'd0;
      exp_fail = 16'd0;

      log_a.delete();
      press_a(1'b1, 1'b0, 1000);
      repeat (20) @(negedge clk);
      chk("held btn one sweep", log_a.size(), 4);
      chk("held btn idle", a_l1, 1'b1);

      stuck[0] = 1'b1;
      log_a.delete();
      press_a(1'b1, 1'b0, 4);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (log_a.size() >= 1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("stuck first op", ok, 1);
      cnt = 0;
`ifdef FLASH_BIST_TIMEOUT_EN
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         cnt++;
         if (a_l3) break;
      end
      chk("tmo done", a_l3, 1'b1);
      chk("tmo after limit", (cnt >= 1015 && cnt <= 1035), 1);
      chk("tmo err_count", a_err, 8'hFF);
      chk("tmo fail_addr", a_fail, 16'h01AA);
      chk("tmo leds", {a_l1, a_l2, a_l3}, 3'b011);
      stuck[0] = 1'b0;
      wait_for(1, 400, ok);
      chk("tmo idle", ok, 1);
`else
      repeat (1500) @(negedge clk);
      chk("stuck still running", {a_l1, a_l2, a_l3}, 3'b010);
      chk("stuck single op", log_a.size(), 1);
      chk("stuck err_count", a_err, 8'd0);
      stuck[0] = 1'b0;
      wait_for(0, 2000, ok);
      chk("stuck resumes", ok, 1);
      chk("stuck resumed ops", log_a.size(), 4);
      wait_for(1, 400, ok);
      chk("stuck idle", ok, 1);
`endif

      chk("protocol violations", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
